// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: grants one requester, runs a fixed-length read/write access, pulses done.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise requester 0 has fixed priority.
//
// state  | meaning
// IDLE   | waiting for a request; winner's command is latched on the granting edge
// ACCESS | memory strobe held for ACCESS_CYCLES cycles, counter runs down to zero
// DONE   | strobes low, doneN pulses for one cycle, gntN still high
module mem_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  inout  wire  [7:0] mem_data,
  output logic       mrd,
  output logic       mwr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;
  logic [7:0] wdata_q;
  logic       pick1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_gnt1;

  // On contention the requester that did not win last time goes first.
  always_comb pick1 = req1 && (!req0 || !last_gnt1);

  always_ff @(posedge clk) begin
    if (!rst_n)
      last_gnt1 <= 1'b1;
    else if (state == IDLE && (req0 || req1))
      last_gnt1 <= pick1;
  end
`else
  always_comb pick1 = req1 && !req0;
`endif

  assign mem_data = mwr ? wdata_q : 8'hzz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rdata    <= 8'h00;
      mem_addr <= 8'h00;
      mrd      <= 1'b0;
      mwr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state    <= ACCESS;
            cnt      <= CNT_LOAD;
            gnt0     <= !pick1;
            gnt1     <= pick1;
            we_q     <= pick1 ? we1 : we0;
            wdata_q  <= pick1 ? wdata1 : wdata0;
            mem_addr <= pick1 ? addr1 : addr0;
            mrd      <= !(pick1 ? we1 : we0);
            mwr      <= pick1 ? we1 : we0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            mrd      <= 1'b0;
            mwr      <= 1'b0;
            mem_addr <= 8'h00;
            done0    <= gnt0;
            done1    <= gnt1;
            // Memory is still driving the bus on this edge since mrd is high.
            if (!we_q)
              rdata <= mem_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done0 <= 1'b0;
          done1 <= 1'b0;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions queued at stimulus time, checked on done.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = 8'h00, addr1 = 8'h00, wdata0 = 8'h00, wdata1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, mrd, mwr;
  logic [7:0] rdata, mem_addr;
  wire  [7:0] mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         who;
    logic [7:0] rdata;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] rd_model = 8'h00;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .mrd(mrd), .mwr(mwr)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten locations read as addr ^ 8'hB5 (so 8'h10 reads 8'hA5).
  logic [7:0] mem   [256];
  logic       valid [256];
  logic [7:0] rd_val;
  initial for (int i = 0; i < 256; i++) valid[i] = 1'b0;
  always @(posedge clk) begin
    if (mwr) begin
      mem[mem_addr]   <= mem_data;
      valid[mem_addr] <= 1'b1;
    end
  end
  always_comb rd_val = valid[mem_addr] ? mem[mem_addr] : (mem_addr ^ 8'hB5);
  assign mem_data = mrd ? rd_val : 8'hzz;

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return valid[a] ? mem[a] : (a ^ 8'hB5);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_model = 8'h00;
  endtask

  // Watches one transaction until a done pulse (bounded); gathers observations only.
  task automatic observe(input logic [7:0] exp_addr, input logic [7:0] exp_wdata,
                         input bit drop, input bit chg,
                         output int lat, output int rd_cyc, output int wr_cyc,
                         output int bad_addr, output int bad_data, output int both,
                         output bit who, output logic [7:0] rd);
    lat = -1; rd_cyc = 0; wr_cyc = 0; bad_addr = 0; bad_data = 0; both = 0;
    who = 1'b0; rd = 8'hxx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && drop) begin req0 = 1'b0; req1 = 1'b0; end
      if (c == 1 && chg) begin addr0 = 8'h55; we0 = 1'b1; wdata0 = 8'hFF; end
      if (mrd) rd_cyc++;
      if (mwr) wr_cyc++;
      if ((mrd || mwr) && mem_addr !== exp_addr) bad_addr++;
      if (!(mrd || mwr) && mem_addr !== 8'h00) bad_addr++;
      if (mwr && mem_data !== exp_wdata) bad_data++;
      if (mrd && mwr) both++;
      if (done0 || done1) begin
        lat = c; who = done1; rd = rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    repeat (2) @(negedge clk);
    n_cmp++; if ({gnt0, gnt1} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt got %b want 00", {gnt0, gnt1}); end
    n_cmp++; if ({done0, done1, mrd, mwr} !== 4'b0000) begin n_bad++; $display("FAIL reset_strobes got %b want 0000", {done0, done1, mrd, mwr}); end
    n_cmp++; if (mem_addr !== 8'h00 || rdata !== 8'h00) begin n_bad++; $display("FAIL reset_buses got addr=%h rdata=%h want 00/00", mem_addr, rdata); end
    req0 = 1'b0;
    rst_n = 1'b1;
    rd_model = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if ({gnt0, gnt1, mrd} !== 3'b000) begin n_bad++; $display("FAIL idle_no_req got %b want 000", {gnt0, gnt1, mrd}); end
  endtask

  task automatic test_single_read();
    int lat, rc, wc, ba, bd, bo; bit who; logic [7:0] rd; exp_t e;
    rd_model = model_rd(8'h10);
    sb.push_back('{who: 1'b0, rdata: rd_model});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    observe(8'h10, 8'h00, 1'b1, 1'b0, lat, rc, wc, ba, bd, bo, who, rd);
    e = sb.pop_front();
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL read_latency got %0d want 3", lat); end
    n_cmp++; if (rc !== 2 || wc !== 0) begin n_bad++; $display("FAIL read_strobes got mrd=%0d mwr=%0d want 2/0", rc, wc); end
    n_cmp++; if (ba !== 0 || bo !== 0) begin n_bad++; $display("FAIL read_addr_bus got bad=%0d both=%0d want 0/0", ba, bo); end
    n_cmp++; if (who !== e.who || rd !== e.rdata) begin n_bad++; $display("FAIL read_sb got who=%0d rdata=%h want %0d/%h", who, rd, e.who, e.rdata); end
    @(negedge clk);
    n_cmp++; if ({done0, gnt0} !== 2'b00) begin n_bad++; $display("FAIL read_done_once got %b want 00", {done0, gnt0}); end
  endtask

  task automatic test_single_write();
    int lat, rc, wc, ba, bd, bo; bit who; logic [7:0] rd; exp_t e;
    sb.push_back('{who: 1'b1, rdata: rd_model});
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    observe(8'h20, 8'h3C, 1'b1, 1'b0, lat, rc, wc, ba, bd, bo, who, rd);
    e = sb.pop_front();
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL write_latency got %0d want 3", lat); end
    n_cmp++; if (wc !== 2 || rc !== 0) begin n_bad++; $display("FAIL write_strobes got mwr=%0d mrd=%0d want 2/0", wc, rc); end
    n_cmp++; if (bd !== 0 || ba !== 0 || bo !== 0) begin n_bad++; $display("FAIL write_bus got data=%0d addr=%0d both=%0d want 0", bd, ba, bo); end
    n_cmp++; if (who !== e.who || rd !== e.rdata) begin n_bad++; $display("FAIL write_sb got who=%0d rdata=%h want %0d/%h", who, rd, e.who, e.rdata); end
    n_cmp++; if (valid[8'h20] !== 1'b1 || mem[8'h20] !== 8'h3C) begin n_bad++; $display("FAIL write_mem got %h want 3c", mem[8'h20]); end
    @(negedge clk);
    n_cmp++; if ({done1, gnt1} !== 2'b00) begin n_bad++; $display("FAIL write_done_once got %b want 00", {done1, gnt1}); end
    we1 = 1'b0;
  endtask

  task automatic test_input_change();
    int lat, rc, wc, ba, bd, bo; bit who; logic [7:0] rd; exp_t e;
    rd_model = model_rd(8'h10);
    sb.push_back('{who: 1'b0, rdata: rd_model});
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    observe(8'h10, 8'h00, 1'b1, 1'b1, lat, rc, wc, ba, bd, bo, who, rd);
    e = sb.pop_front();
    n_cmp++; if (ba !== 0) begin n_bad++; $display("FAIL chg_addr_held got bad=%0d want 0", ba); end
    n_cmp++; if (rc !== 2 || wc !== 0) begin n_bad++; $display("FAIL chg_we_held got mrd=%0d mwr=%0d want 2/0", rc, wc); end
    n_cmp++; if (who !== e.who || rd !== e.rdata) begin n_bad++; $display("FAIL chg_sb got who=%0d rdata=%h want %0d/%h", who, rd, e.who, e.rdata); end
    we0 = 1'b0; addr0 = 8'h10;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int seen_done;
    do_reset();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    @(negedge clk);
    n_cmp++; if (mrd !== 1'b1) begin n_bad++; $display("FAIL rst_mid_start got mrd=%b want 1", mrd); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({mrd, gnt0} !== 2'b00) begin n_bad++; $display("FAIL rst_mid_abort got %b want 00", {mrd, gnt0}); end
    rst_n = 1'b1; req0 = 1'b0;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || done1) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL rst_mid_done got %0d pulses want 0", seen_done); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL rst_mid_rdata got %h want 00", rdata); end
  endtask

  task automatic test_back_to_back();
    int lat, rc, wc, ba, bd, bo; bit who; logic [7:0] rd; exp_t e; bit w;
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h40;
    for (int i = 0; i < 4; i++) begin
      w = RR ? i[0] : 1'b0;
      rd_model = model_rd(w ? 8'h40 : 8'h10);
      sb.push_back('{who: w, rdata: rd_model});
      observe(w ? 8'h40 : 8'h10, 8'h00, 1'b0, 1'b0, lat, rc, wc, ba, bd, bo, who, rd);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      e = sb.pop_front();
      n_cmp++; if (who !== e.who || rd !== e.rdata) begin n_bad++; $display("FAIL contend_sb[%0d] got who=%0d rdata=%h want %0d/%h", i, who, rd, e.who, e.rdata); end
      n_cmp++; if (lat !== (i == 0 ? 3 : 4)) begin n_bad++; $display("FAIL contend_lat[%0d] got %0d want %0d", i, lat, i == 0 ? 3 : 4); end
      n_cmp++; if (ba !== 0 || bo !== 0 || rc !== 2) begin n_bad++; $display("FAIL contend_bus[%0d] got addr=%0d both=%0d mrd=%0d", i, ba, bo, rc); end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if ({gnt0, gnt1, mrd} !== 3'b000) begin n_bad++; $display("FAIL contend_release got %b want 000", {gnt0, gnt1, mrd}); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_input_change();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2: number of cycles mrd/mwr are held per transaction; legal range 1..15.
REQ-002 SHALL have one clock and a synchronous, active-low reset; all state updates on the rising edge of clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 req0 / req1  input  1  transaction request from requester 0 (core) / 1 (secondary master).
REQ-006 we0 / we1  input  1  1 = write, 0 = read; valid while reqN high.
REQ-007 addr0 / addr1  input  8  transaction address.
REQ-008 wdata0 / wdata1  input  8  write data.
REQ-009 gnt0 / gnt1  output  1  requester N owns the memory bus; at most one high.
REQ-010 done0 / done1  output  1  one-cycle completion pulse to requester N.
REQ-011 rdata  output  8  last read data captured from the memory bus.
REQ-012 mem_addr  output  8  memory address bus.
REQ-013 mem_data  inout  8  bidirectional memory data bus.
REQ-014 mrd / mwr  output  1  active-high memory read / write strobes.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-016 IDLE: sample req0/req1 each edge; if any high, latch winner's we/addr/wdata, set gntN, load cycle counter with ACCESS_CYCLES-1, go ACCESS; else stay IDLE.
REQ-017 ACCESS: drive mem_addr = latched address; assert mrd (read) or mwr (write); decrement counter each edge; go DONE when counter = 0.
REQ-018 Read data SHALL be captured into rdata on the edge leaving ACCESS; rdata holds until next read completes.
REQ-019 DONE: mrd = mwr = 0, doneN = 1 for exactly one cycle, gntN stays high; next state IDLE, gntN cleared.
REQ-020 Latency: request seen high at edge k -> ACCESS during cycles k..k+ACCESS_CYCLES-1 -> done during cycle k+ACCESS_CYCLES.
REQ-021 mem_data SHALL be driven with latched wdata only while mwr = 1; high-Z otherwise.
REQ-022 mrd and mwr SHALL never be high simultaneously.
REQ-023 In IDLE and DONE mem_addr SHALL be 8'h00.
REQ-024 Requester inputs SHALL be ignored after latching; changes to addr/we/wdata mid-transaction have no effect.
REQ-025 reqN still high in the IDLE cycle after doneN counts as a new request (back-to-back allowed, one idle cycle between transactions).
REQ-026 A requester dropping reqN mid-transaction SHALL NOT abort it; done still pulses.

Reset
REQ-027 rst_n low at an edge: state = IDLE, gnt0 = gnt1 = 0, done0 = done1 = 0, mrd = mwr = 0, mem_addr = 8'h00, rdata = 8'h00, mem_data high-Z, priority pointer favours requester 0.
REQ-028 Reset during ACCESS SHALL abandon the transaction: strobes drop at that edge, no done pulse, rdata not updated.

Configuration
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous req0 and req1 in IDLE, grant the requester not granted most recently (pointer updated on each grant).
REQ-030 Macro undefined: fixed priority, req0 always wins simultaneous requests; no pointer state.
REQ-031 Single-request behaviour SHALL be identical in both configurations.

Verification
REQ-032 Reset: rst_n = 0 for 2 cycles with req0 = 1 -> all outputs at REQ-027 values, no gnt.
REQ-033 Single read: req0 = 1, we0 = 0, addr0 = 8'h10, memory returns 8'hA5, ACCESS_CYCLES = 2 -> mrd high 2 cycles, mem_addr = 8'h10, done0 on 3rd cycle, rdata = 8'hA5.
REQ-034 Single write: req1 = 1, we1 = 1, addr1 = 8'h20, wdata1 = 8'h3C -> mwr high 2 cycles, mem_data = 8'h3C only then, memory location 8'h20 = 8'h3C, done1 pulses once.
REQ-035 Contention: req0 = req1 = 1 held through 4 transactions -> with MEM_ARB_ROUND_ROBIN_EN grants 0,1,0,1; without it grants 0,0,0,0.
REQ-036 Reset mid-ACCESS: rst_n = 0 in first ACCESS cycle of read to 8'h10 -> mrd low next cycle, no done0, rdata unchanged 8'h00.
REQ-037 Input change: addr0 changed 8'h10 -> 8'h55 during ACCESS -> mem_addr stays 8'h10 through transaction.
